// File: rtl/dm_sba_if.sv
// System-bus req/gnt/rvalid handshake between the SBA master and the SoC interconnect.
interface dm_sba_if #(
  parameter int BUS_AW = 32,
  parameter int BUS_DW = 32
);
  logic                req;
  logic                we;
  logic [BUS_AW-1:0]   addr;
  logic [BUS_DW-1:0]   wdata;
  logic [BUS_DW/8-1:0] be;
  logic                gnt;
  logic                rvalid;
  logic [BUS_DW-1:0]   rdata;
  logic                err;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dm_sba_master.sv
// Debug-module System Bus Access: SBCS/SBADDRESS/SBDATA register front-end plus bus master FSM.
// Optional watchdog on stuck bus accesses enabled by defining SBA_TIMEOUT_EN.
module dm_sba_master #(
  parameter int BUS_AW      = 32,
  parameter int BUS_DW      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmi_req_valid_i,
  input  logic [6:0]  dmi_req_addr_i,
  input  logic [1:0]  dmi_req_op_i,
  input  logic [31:0] dmi_req_data_i,
  output logic        dmi_resp_valid_o,
  output logic [31:0] dmi_resp_data_o,
  dm_sba_if.master    sb
);
  localparam int         NB     = BUS_DW / 8;
  localparam int         OFFW   = $clog2(NB);
  localparam bit         HAS_A1 = (BUS_AW > 32);
  localparam bit         HAS_D1 = (BUS_DW == 64);
  localparam logic [2:0] MAXACC = HAS_D1 ? 3'd3 : 3'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e state_q, state_d;

  logic [BUS_AW-1:0] sbaddr_q, sbaddr_d;
  logic [BUS_DW-1:0] sbdata_q, sbdata_d;
  logic              busyerr_q, busyerr_d, rdonaddr_q, rdonaddr_d;
  logic              autoinc_q, autoinc_d, rdondata_q, rdondata_d;
  logic [2:0]        access_q, access_d, sberror_q, sberror_d;
  logic              acc_we_q, acc_we_d;
  logic [2:0]        acc_sz_q, acc_sz_d;
  logic              resp_valid_q;
  logic [31:0]       resp_data_q, resp_data_d;

  logic              busy, wr, rd, noerr, trig, trig_we, start, done, to_hit;
  logic [63:0]       addr64, data64;
  logic [31:0]       sbcs;
  logic [OFFW-1:0]   off;
  logic [OFFW+2:0]   sh;
  logic [15:0]       be16;
  logic [NB-1:0]     be_lane;
  logic [BUS_DW-1:0] bmask, rd_lane, wr_lane;

  assign busy   = (state_q != IDLE);
  assign wr     = dmi_req_valid_i && (dmi_req_op_i == 2'b10);
  assign rd     = dmi_req_valid_i && (dmi_req_op_i == 2'b01);
  assign noerr  = (sberror_q == 3'd0) && !busyerr_q;
  assign addr64 = 64'(sbaddr_q);
  assign data64 = 64'(sbdata_q);
  assign sbcs   = {3'd1, 6'd0, busyerr_q, busy, rdonaddr_q, access_q, autoinc_q, rdondata_q,
                   sberror_q, 7'(BUS_AW), 1'b0, HAS_D1, 3'b111};

  // Lane placement uses the size latched at trigger time, so SBCS edits mid-access are harmless.
  assign off     = sbaddr_q[OFFW-1:0];
  assign sh      = {off, 3'b000};
  assign be16    = ((16'd1 << (5'd1 << acc_sz_q)) - 16'd1) << off;
  assign be_lane = be16[NB-1:0];
  always_comb begin
    bmask = '0;
    for (int i = 0; i < NB; i++) bmask[i*8 +: 8] = {8{be_lane[i]}};
  end
  assign rd_lane = (sb.rdata & bmask) >> sh;
  assign wr_lane = sbdata_q << sh;

  assign done = ((state_q == WAIT) && sb.rvalid) || ((state_q == REQ) && sb.gnt && sb.rvalid);

`ifdef SBA_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  assign to_hit = busy && !done && (to_cnt_q == 32'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                    to_cnt_q <= '0;
    else if (busy && !done && !to_hit) to_cnt_q <= to_cnt_q + 32'd1;
    else                            to_cnt_q <= '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Register decode, trigger pre-checks and access completion.
  always_comb begin
    sbaddr_d    = sbaddr_q;
    sbdata_d    = sbdata_q;
    busyerr_d   = busyerr_q;
    rdonaddr_d  = rdonaddr_q;
    autoinc_d   = autoinc_q;
    rdondata_d  = rdondata_q;
    access_d    = access_q;
    sberror_d   = sberror_q;
    acc_we_d    = acc_we_q;
    acc_sz_d    = acc_sz_q;
    resp_data_d = '0;
    trig        = 1'b0;
    trig_we     = 1'b0;
    start       = 1'b0;

    if (rd) begin
      case (dmi_req_addr_i)
        7'h38:   resp_data_d = sbcs;
        7'h39:   resp_data_d = addr64[31:0];
        7'h3A:   resp_data_d = HAS_A1 ? addr64[63:32] : 32'd0;
        7'h3C:   resp_data_d = data64[31:0];
        7'h3D:   resp_data_d = HAS_D1 ? data64[63:32] : 32'd0;
        default: resp_data_d = '0;
      endcase
      if ((dmi_req_addr_i == 7'h3C) || (HAS_D1 && dmi_req_addr_i == 7'h3D)) begin
        if (busy) busyerr_d = 1'b1;
        else if (dmi_req_addr_i == 7'h3C && rdondata_q && noerr) trig = 1'b1;
      end
    end

    if (wr) begin
      case (dmi_req_addr_i)
        7'h38: begin
          busyerr_d  = busyerr_q & ~dmi_req_data_i[22];
          rdonaddr_d = dmi_req_data_i[20];
          access_d   = dmi_req_data_i[19:17];
          autoinc_d  = dmi_req_data_i[16];
          rdondata_d = dmi_req_data_i[15];
          sberror_d  = sberror_q & ~dmi_req_data_i[14:12];
        end
        7'h39: begin
          if (busy) busyerr_d = 1'b1;
          else begin
            sbaddr_d = BUS_AW'({addr64[63:32], dmi_req_data_i});
            trig     = rdonaddr_q && noerr;
          end
        end
        7'h3A: if (HAS_A1) begin
          if (busy) busyerr_d = 1'b1;
          else      sbaddr_d  = BUS_AW'({dmi_req_data_i, addr64[31:0]});
        end
        7'h3C: begin
          if (busy) busyerr_d = 1'b1;
          else begin
            sbdata_d = BUS_DW'({data64[63:32], dmi_req_data_i});
            trig     = noerr;
            trig_we  = 1'b1;
          end
        end
        7'h3D: if (HAS_D1) begin
          if (busy) busyerr_d = 1'b1;
          else      sbdata_d  = BUS_DW'({dmi_req_data_i, data64[31:0]});
        end
        default: ;
      endcase
    end

    if (trig) begin
      if (access_q > MAXACC)                                        sberror_d = 3'd4;
      else if (|(sbaddr_d[2:0] & (3'(1 << access_q) - 3'd1)))       sberror_d = 3'd3;
      else begin
        start    = 1'b1;
        acc_we_d = trig_we;
        acc_sz_d = access_q;
      end
    end

    if (done) begin
      if (sb.err) sberror_d = 3'd2;
      else begin
        if (!acc_we_q) sbdata_d = rd_lane;
        if (autoinc_q) sbaddr_d = sbaddr_q + (BUS_AW'(1) << acc_sz_q);
      end
    end
    if (to_hit) sberror_d = 3'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (sb.gnt) state_d = sb.rvalid ? IDLE : WAIT;
      WAIT:    if (sb.rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (to_hit) state_d = IDLE;
  end

  always_comb begin
    sb.req   = 1'b0;
    sb.we    = 1'b0;
    sb.addr  = '0;
    sb.wdata = '0;
    sb.be    = '0;
    if (state_q == REQ) begin
      sb.req   = 1'b1;
      sb.we    = acc_we_q;
      sb.addr  = sbaddr_q;
      sb.wdata = acc_we_q ? wr_lane : '0;
      sb.be    = be_lane;
    end
  end

  assign dmi_resp_valid_o = resp_valid_q;
  assign dmi_resp_data_o  = resp_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sbaddr_q     <= '0;
      sbdata_q     <= '0;
      busyerr_q    <= 1'b0;
      rdonaddr_q   <= 1'b0;
      autoinc_q    <= 1'b0;
      rdondata_q   <= 1'b0;
      access_q     <= 3'd2;
      sberror_q    <= 3'd0;
      acc_we_q     <= 1'b0;
      acc_sz_q     <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      sbaddr_q     <= sbaddr_d;
      sbdata_q     <= sbdata_d;
      busyerr_q    <= busyerr_d;
      rdonaddr_q   <= rdonaddr_d;
      autoinc_q    <= autoinc_d;
      rdondata_q   <= rdondata_d;
      access_q     <= access_d;
      sberror_q    <= sberror_d;
      acc_we_q     <= acc_we_d;
      acc_sz_q     <= acc_sz_d;
      resp_valid_q <= dmi_req_valid_i;
      resp_data_q  <= resp_data_d;
    end
  end
endmodule
